rr_multiplexer: RTL and testbench



---
 rtl/rr_multiplexer.sv | 113 +++++++++++
 tb/tb_rr_multiplexer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_multiplexer.sv
// Four-channel round-robin multiplexer: serialises W/X/Y/Z words onto a
// registered A/SEL pair with valid/ready handshakes on every channel.
module rr_multiplexer #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] W,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [WIDTH-1:0] Z,
  input  logic             W_VALID,
  input  logic             X_VALID,
  input  logic             Y_VALID,
  input  logic             Z_VALID,
  output logic             W_READY,
  output logic             X_READY,
  output logic             Y_READY,
  output logic             Z_READY,
  output logic [WIDTH-1:0] A,
  output logic [1:0]       SEL,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;

  logic             load;
  logic [3:0]       valid_vec;
  logic [3:0]       ready_vec;
  logic [1:0]       cand;
  logic             grant_found;
  logic [1:0]       grant_idx;
  logic [WIDTH-1:0] grant_data;

  // Rotating priority search starting at ptr_q; first valid channel wins.
  always_comb begin
    load        = !out_valid_q || OUT_READY;
    valid_vec   = {Z_VALID, Y_VALID, X_VALID, W_VALID};
    cand        = '0;
    grant_found = 1'b0;
    grant_idx   = ptr_q;
    for (int unsigned i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!grant_found && valid_vec[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    grant_data = W;
    case (grant_idx)
      2'd0: grant_data = W;
      2'd1: grant_data = X;
      2'd2: grant_data = Y;
      2'd3: grant_data = Z;
      default: grant_data = W;
    endcase
  end

  // READY is gated by rst so no source handshake completes while reset is held.
  always_comb begin
    ready_vec = '0;
    if (load && grant_found && !rst) begin
      ready_vec[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    a_d         = a_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    if (load) begin
      if (grant_found) begin
        a_d         = grant_data;
        sel_d       = grant_idx;
        ptr_d       = grant_idx + 2'd1;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= '0;
      sel_q       <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      a_q         <= a_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign W_READY   = ready_vec[0];
  assign X_READY   = ready_vec[1];
  assign Y_READY   = ready_vec[2];
  assign Z_READY   = ready_vec[3];
  assign A         = a_q;
  assign SEL       = sel_q;
  assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_rr_multiplexer.sv
// Scoreboard bench for rr_multiplexer: directed stimulus pushes expected
// {SEL,A} words; a negedge monitor pops them on every output transfer.
module tb_rr_multiplexer;

  localparam int unsigned WIDTH = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] W, X, Y, Z;
  logic             W_VALID, X_VALID, Y_VALID, Z_VALID;
  logic             W_READY, X_READY, Y_READY, Z_READY;
  logic [WIDTH-1:0] A;
  logic [1:0]       SEL;
  logic             OUT_VALID;
  logic             OUT_READY;

  int checks = 0;
  int errors = 0;
  logic [WIDTH+1:0] exp_q[$];

  rr_multiplexer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .W(W), .X(X), .Y(Y), .Z(Z),
    .W_VALID(W_VALID), .X_VALID(X_VALID), .Y_VALID(Y_VALID), .Z_VALID(Z_VALID),
    .W_READY(W_READY), .X_READY(X_READY), .Y_READY(Y_READY), .Z_READY(Z_READY),
    .A(A), .SEL(SEL), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_valid(input logic [3:0] v);
    {Z_VALID, Y_VALID, X_VALID, W_VALID} = v;
  endtask

  function automatic logic [3:0] readies();
    return {Z_READY, Y_READY, X_READY, W_READY};
  endfunction

  // Monitor: an output transfer happens at the next edge when OUT_VALID && OUT_READY.
  always @(negedge clk) begin
    if (!rst && OUT_VALID && OUT_READY) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word actual_sel=%0d actual_a=%0h expected=none at %0t", SEL, A, $time);
      end else begin
        logic [WIDTH+1:0] e;
        e = exp_q.pop_front();
        if ({SEL, A} !== e) begin
          errors++;
          $display("FAIL out_word actual_sel=%0d actual_a=%0h expected_sel=%0d expected_a=%0h at %0t",
                   SEL, A, e[WIDTH+1:WIDTH], e[WIDTH-1:0], $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    W = '0; X = '0; Y = '0; Z = '0;
    set_valid(4'b0000);
    OUT_READY = 1'b0;
    #1;
    chk("reset_out_valid", 32'(OUT_VALID), 0);
    chk("reset_a_sel", 32'({SEL, A}), 0);
    cycle();
    cycle();
    rst = 1'b0;

    // 1: load a W word, then assert reset mid-cycle and check immediate clear
    W = 2'b11; W_VALID = 1'b1;
    #1;
    chk("t1_w_ready_pre", 32'(readies()), 32'b0001);
    cycle();
    chk("t1_loaded", 32'({OUT_VALID, SEL, A}), 32'b1_00_11);
    chk("t1_bp_ready", 32'(readies()), 0);
    #5;
    rst = 1'b1;
    #1;
    chk("t1_async_out_valid", 32'(OUT_VALID), 0);
    chk("t1_async_a_sel", 32'({SEL, A}), 0);
    chk("t1_ready_in_reset", 32'(readies()), 0);
    rst = 1'b0;
    OUT_READY = 1'b1;
    exp_q.push_back({2'd0, 2'b11});
    #1;
    chk("t1_w_ready_post", 32'(readies()), 32'b0001);
    cycle();
    W_VALID = 1'b0;
    chk("t1_after_release", 32'({OUT_VALID, SEL, A}), 32'b1_00_11);
    cycle();
    chk("t1_idle", 32'(OUT_VALID), 0);

    // 2: single Y word for one cycle
    Y = 2'b01; Y_VALID = 1'b1;
    exp_q.push_back({2'd2, 2'b01});
    #1;
    chk("t2_y_ready", 32'(readies()), 32'b0100);
    cycle();
    Y_VALID = 1'b0;
    chk("t2_out", 32'({OUT_VALID, SEL, A}), 32'b1_10_01);
    cycle();
    chk("t2_drain", 32'(OUT_VALID), 0);

    // 3: reset pointer, then all channels valid for 8 cycles
    rst = 1'b1;
    #3;
    rst = 1'b0;
    W = 2'b00; X = 2'b01; Y = 2'b10; Z = 2'b11;
    set_valid(4'b1111);
    for (int k = 0; k < 8; k++) begin
      logic [1:0] g;
      g = 2'(k % 4);
      exp_q.push_back({g, g});
    end
    for (int k = 0; k < 8; k++) begin
      logic [3:0] er;
      er = 4'b0001 << (k % 4);
      #1;
      chk("t3_ready_onehot", 32'(readies()), 32'(er));
      cycle();
    end

    // 5: backpressure on the last word (Z, 11) with all channels still valid
    OUT_READY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t5_bp_hold", 32'({OUT_VALID, SEL, A}), 32'b1_11_11);
      chk("t5_bp_ready", 32'(readies()), 0);
      cycle();
    end
    OUT_READY = 1'b1;
    exp_q.push_back({2'd0, 2'b00});
    #1;
    chk("t5_resume_ready", 32'(readies()), 32'b0001);
    cycle();
    set_valid(4'b0000);
    chk("t5_resume_word", 32'({OUT_VALID, SEL, A}), 32'b1_00_00);

    // 6: idle gap holds A/SEL; pointer resumes at X, so Y wins over W
    cycle();
    chk("t6_idle", 32'({OUT_VALID, SEL, A}), 32'b0_00_00);
    cycle();
    chk("t6_idle_hold", 32'({OUT_VALID, SEL, A}), 32'b0_00_00);
    W = 2'b01; Y = 2'b11;
    W_VALID = 1'b1; Y_VALID = 1'b1;
    exp_q.push_back({2'd2, 2'b11});
    #1;
    chk("t6_resume_ptr", 32'(readies()), 32'b0100);
    cycle();
    set_valid(4'b0000);

    // 4: grant X (ptr -> 2), then W and Z together: Z first, then W
    X = 2'b10; X_VALID = 1'b1;
    exp_q.push_back({2'd1, 2'b10});
    #1;
    chk("t4_x_ready", 32'(readies()), 32'b0010);
    cycle();
    X_VALID = 1'b0;
    W = 2'b01; Z = 2'b00;
    W_VALID = 1'b1; Z_VALID = 1'b1;
    exp_q.push_back({2'd3, 2'b00});
    exp_q.push_back({2'd0, 2'b01});
    #1;
    chk("t4_z_first", 32'(readies()), 32'b1000);
    cycle();
    Z_VALID = 1'b0;
    #1;
    chk("t4_w_second", 32'(readies()), 32'b0001);
    cycle();
    W_VALID = 1'b0;
    cycle();
    cycle();
    chk("final_idle", 32'(OUT_VALID), 0);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
